// File: rtl/fixed_pkg.sv
// rtl/fixed_pkg.sv - signed 32-bit fixed-point type and defaults
package fixed_pkg;

  localparam int FIXED_W           = 32;
  localparam int FRAC_BITS_DEFAULT = 16;

  typedef logic signed [FIXED_W-1:0] fixed_t;

  localparam fixed_t FIXED_MAX = 32'sh7FFF_FFFF;
  localparam fixed_t FIXED_MIN = 32'sh8000_0000;

endpackage

// File: rtl/fixed_mul_sat.sv
// rtl/fixed_mul_sat.sv - combinational saturating fixed-point multiply
module fixed_mul_sat
  import fixed_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  fixed_t a,
  input  fixed_t b,
  output fixed_t p
);

  localparam logic signed [63:0] SAT_HI = 64'sd2147483647;
  localparam logic signed [63:0] SAT_LO = -64'sd2147483648;

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] prod;
  logic signed [63:0] shifted;

  // Full-width product, rescale by the fraction, clamp into the 32-bit range
  always_comb begin
    a_ext   = {{32{a[31]}}, a};
    b_ext   = {{32{b[31]}}, b};
    prod    = a_ext * b_ext;
    shifted = prod >>> FRAC_BITS;
    if (shifted > SAT_HI) begin
      p = FIXED_MAX;
    end else if (shifted < SAT_LO) begin
      p = FIXED_MIN;
    end else begin
      p = shifted[31:0];
    end
  end

endmodule

// File: rtl/perspective_divide.sv
// rtl/perspective_divide.sv - clip-space vertex divide by w via external divider
module perspective_divide
  import fixed_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  fixed_t       in_x,
  input  fixed_t       in_y,
  input  fixed_t       in_z,
  input  fixed_t       in_w,
  output logic         div_dividend_tvalid,
  input  logic         div_dividend_tready,
  output logic [32:0]  div_dividend_tdata,
  output logic         div_divisor_tvalid,
  input  logic         div_divisor_tready,
  output logic [31:0]  div_divisor_tdata,
  input  logic         div_dout_tvalid,
  output logic         div_dout_tready,
  input  logic [39:0]  div_dout_tdata,
  output logic         out_valid,
  input  logic         out_ready,
  output fixed_t       out_x,
  output fixed_t       out_y,
  output fixed_t       out_z,
  output fixed_t       out_w_recip,
  output logic         out_div_by_zero
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    MUL_X,
    MUL_Y,
    MUL_Z,
    OUT
  } state_t;

  // 1.0 / w computed as 2^(2F) / w keeps the quotient in the same Q format
  localparam logic [32:0] DIVIDEND_ONE = 33'd1 << (2 * FRAC_BITS);

  state_t state_q, state_d;
  fixed_t x_q, x_d;
  fixed_t y_q, y_d;
  fixed_t z_q, z_d;
  fixed_t w_q, w_d;
  fixed_t recip_q, recip_d;
  fixed_t out_x_q, out_x_d;
  fixed_t out_y_q, out_y_d;
  fixed_t out_z_q, out_z_d;
  logic   dbz_q, dbz_d;
  logic   dvd_tvalid_q, dvd_tvalid_d;
  logic   dvs_tvalid_q, dvs_tvalid_d;

  fixed_t mul_a;
  fixed_t mul_p;
  logic   dvd_done;
  logic   dvs_done;
  logic   unused_dout_hi;

  // Single shared multiplier; the state picks which component feeds it
  fixed_mul_sat #(
    .FRAC_BITS(FRAC_BITS)
  ) u_mul (
    .a(mul_a),
    .b(recip_q),
    .p(mul_p)
  );

  assign in_ready            = (state_q == IDLE);
  assign out_valid           = (state_q == OUT);
  assign div_dout_tready     = (state_q == IDLE) || (state_q == WAIT);
  assign div_dividend_tvalid = dvd_tvalid_q;
  assign div_divisor_tvalid  = dvs_tvalid_q;
  assign div_dividend_tdata  = DIVIDEND_ONE;
  assign div_divisor_tdata   = w_q;
  assign out_x               = out_x_q;
  assign out_y               = out_y_q;
  assign out_z               = out_z_q;
  assign out_w_recip         = recip_q;
  assign out_div_by_zero     = dbz_q;
  assign unused_dout_hi      = ^div_dout_tdata[39:32];

  // A channel is finished once its tvalid is low or is being accepted now
  assign dvd_done = !dvd_tvalid_q || div_dividend_tready;
  assign dvs_done = !dvs_tvalid_q || div_divisor_tready;

  // Next-state, datapath and handshake control
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    z_d          = z_q;
    w_d          = w_q;
    recip_d      = recip_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_z_d      = out_z_q;
    dbz_d        = dbz_q;
    dvd_tvalid_d = dvd_tvalid_q;
    dvs_tvalid_d = dvs_tvalid_q;

    case (state_q)
      MUL_X:   mul_a = x_q;
      MUL_Y:   mul_a = y_q;
      default: mul_a = z_q;
    endcase

    case (state_q)
      IDLE: begin
        // A dout beat arriving here is stale and is simply absorbed
        if (in_valid) begin
          x_d = in_x;
          y_d = in_y;
          z_d = in_z;
          w_d = in_w;
          if (in_w != '0) begin
            dbz_d        = 1'b0;
            dvd_tvalid_d = 1'b1;
            dvs_tvalid_d = 1'b1;
            state_d      = ISSUE;
          end else begin
            out_x_d = '0;
            out_y_d = '0;
            out_z_d = '0;
            recip_d = '0;
            dbz_d   = 1'b1;
            state_d = OUT;
          end
        end
      end
      ISSUE: begin
        if (dvd_tvalid_q && div_dividend_tready) begin
          dvd_tvalid_d = 1'b0;
        end
        if (dvs_tvalid_q && div_divisor_tready) begin
          dvs_tvalid_d = 1'b0;
        end
        if (dvd_done && dvs_done) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (div_dout_tvalid) begin
          recip_d = div_dout_tdata[31:0];
          state_d = MUL_X;
        end
      end
      MUL_X: begin
        out_x_d = mul_p;
        state_d = MUL_Y;
      end
      MUL_Y: begin
        out_y_d = mul_p;
        state_d = MUL_Z;
      end
      MUL_Z: begin
        out_z_d = mul_p;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      w_q          <= '0;
      recip_q      <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_z_q      <= '0;
      dbz_q        <= 1'b0;
      dvd_tvalid_q <= 1'b0;
      dvs_tvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      z_q          <= z_d;
      w_q          <= w_d;
      recip_q      <= recip_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_z_q      <= out_z_d;
      dbz_q        <= dbz_d;
      dvd_tvalid_q <= dvd_tvalid_d;
      dvs_tvalid_q <= dvs_tvalid_d;
    end
  end

endmodule

// File: tb/tb_perspective_divide.sv
// tb/tb_perspective_divide.sv - directed vector bench with a mock divider
module tb_perspective_divide;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0;
  logic [31:0] in_y = '0;
  logic [31:0] in_z = '0;
  logic [31:0] in_w = '0;
  logic        div_dividend_tvalid;
  logic        div_dividend_tready = 1'b0;
  logic [32:0] div_dividend_tdata;
  logic        div_divisor_tvalid;
  logic        div_divisor_tready = 1'b0;
  logic [31:0] div_divisor_tdata;
  logic        div_dout_tvalid = 1'b0;
  logic        div_dout_tready;
  logic [39:0] div_dout_tdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_x;
  logic [31:0] out_y;
  logic [31:0] out_z;
  logic [31:0] out_w_recip;
  logic        out_div_by_zero;

  always #5 clk = ~clk;

  perspective_divide #(.FRAC_BITS(16)) dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_x                (in_x),
    .in_y                (in_y),
    .in_z                (in_z),
    .in_w                (in_w),
    .div_dividend_tvalid (div_dividend_tvalid),
    .div_dividend_tready (div_dividend_tready),
    .div_dividend_tdata  (div_dividend_tdata),
    .div_divisor_tvalid  (div_divisor_tvalid),
    .div_divisor_tready  (div_divisor_tready),
    .div_divisor_tdata   (div_divisor_tdata),
    .div_dout_tvalid     (div_dout_tvalid),
    .div_dout_tready     (div_dout_tready),
    .div_dout_tdata      (div_dout_tdata),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_x               (out_x),
    .out_y               (out_y),
    .out_z               (out_z),
    .out_w_recip         (out_w_recip),
    .out_div_by_zero     (out_div_by_zero)
  );

  // Mock divider: independent input channels, fixed latency, in-order results
  localparam int DIV_LAT = 4;

  typedef struct {
    logic [39:0] q;
    int          due;
  } pend_t;

  pend_t       pq[$];
  pend_t       popped;
  int          cyc = 0;
  int          dly_a = 0;
  int          dly_b = 0;
  int          cnt_a = 0;
  int          cnt_b = 0;
  bit          have_a = 0;
  bit          have_b = 0;
  logic [32:0] dvd_v;
  logic [31:0] dvs_v;
  int          tv_seen = 0;
  int          beats = 0;

  function automatic logic [39:0] model_div(input logic [32:0] n, input logic [31:0] d);
    longint nn;
    longint dd;
    longint q;
    nn = longint'({31'b0, n});
    dd = longint'(signed'(d));
    q  = nn / dd;
    return {{8{q[31]}}, q[31:0]};
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (div_dividend_tvalid || div_divisor_tvalid) tv_seen = tv_seen + 1;
    if (div_dividend_tvalid && div_dividend_tready) begin
      have_a = 1; dvd_v = div_dividend_tdata; cnt_a = 0;
    end else if (div_dividend_tvalid) begin
      cnt_a = cnt_a + 1;
    end
    if (div_divisor_tvalid && div_divisor_tready) begin
      have_b = 1; dvs_v = div_divisor_tdata; cnt_b = 0;
    end else if (div_divisor_tvalid) begin
      cnt_b = cnt_b + 1;
    end
    if (have_a && have_b) begin
      pq.push_back('{q: model_div(dvd_v, dvs_v), due: cyc + DIV_LAT});
      have_a = 0;
      have_b = 0;
    end
    if (div_dout_tvalid && div_dout_tready) begin
      popped = pq.pop_front();
      beats = beats + 1;
    end
    div_dividend_tready <= !have_a && (cnt_a >= dly_a);
    div_divisor_tready  <= !have_b && (cnt_b >= dly_b);
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      div_dout_tvalid <= 1'b1;
      div_dout_tdata  <= pq[0].q;
    end else begin
      div_dout_tvalid <= 1'b0;
      div_dout_tdata  <= '0;
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    total_cnt = total_cnt + 1;
    if (act === exp) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] x, y, z, w;
    int          dly_a, dly_b;
    logic [31:0] ex, ey, ez, er;
    logic        edbz;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input string tag, input int hold);
    int          n;
    int          tv0;
    bit          stable;
    logic [31:0] sx, sy, sz, sr;
    @(negedge clk);
    dly_a = v.dly_a;
    dly_b = v.dly_b;
    tv0 = tv_seen;
    in_x = v.x; in_y = v.y; in_z = v.z; in_w = v.w;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check({tag, "_accept"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    check({tag, "_out_valid"}, out_valid, 1);
    if (hold > 0) begin
      stable = 1;
      sx = out_x; sy = out_y; sz = out_z; sr = out_w_recip;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (!out_valid || in_ready || out_x !== sx || out_y !== sy ||
            out_z !== sz || out_w_recip !== sr) stable = 0;
      end
      check({tag, "_stall_stable"}, stable, 1);
    end
    check({tag, "_x"}, out_x, v.ex);
    check({tag, "_y"}, out_y, v.ey);
    check({tag, "_z"}, out_z, v.ez);
    check({tag, "_recip"}, out_w_recip, v.er);
    check({tag, "_dbz"}, out_div_by_zero, v.edbz);
    if (v.w == 0) check({tag, "_no_div_tvalid"}, tv_seen - tv0, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_after"}, in_ready, 1);
  endtask

  initial begin
    int n;
    int beats0;
    vecs[0] = '{x:32'h0002_0000, y:32'h0001_0000, z:32'h0000_0000, w:32'h0002_0000,
                dly_a:0, dly_b:0,
                ex:32'h0001_0000, ey:32'h0000_8000, ez:32'h0000_0000, er:32'h0000_8000, edbz:1'b0};
    vecs[1] = '{x:32'h0001_0000, y:32'h0003_0000, z:32'hFFFF_0000, w:32'hFFFC_0000,
                dly_a:3, dly_b:0,
                ex:32'hFFFF_C000, ey:32'hFFFF_4000, ez:32'h0000_4000, er:32'hFFFF_C000, edbz:1'b0};
    vecs[2] = '{x:32'h7FFF_0000, y:32'h8001_0000, z:32'h0001_0000, w:32'h0000_4000,
                dly_a:0, dly_b:3,
                ex:32'h7FFF_FFFF, ey:32'h8000_0000, ez:32'h0004_0000, er:32'h0004_0000, edbz:1'b0};
    vecs[3] = '{x:32'h1234_5678, y:32'h0000_0001, z:32'h0000_0002, w:32'h0000_0000,
                dly_a:0, dly_b:0,
                ex:32'h0, ey:32'h0, ez:32'h0, er:32'h0, edbz:1'b1};
    vecs[4] = '{x:32'h0001_8000, y:32'hFFFF_FFFF, z:32'h7FFF_FFFF, w:32'h0001_0000,
                dly_a:2, dly_b:2,
                ex:32'h0001_8000, ey:32'hFFFF_FFFF, ez:32'h7FFF_FFFF, er:32'h0001_0000, edbz:1'b0};
    vecs[5] = '{x:32'h0003_0000, y:32'hFFFD_0000, z:32'hFFFF_FFFF, w:32'h0003_0000,
                dly_a:1, dly_b:0,
                ex:32'h0000_FFFF, ey:32'hFFFF_0001, ez:32'hFFFF_FFFF, er:32'h0000_5555, edbz:1'b0};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dvd_tvalid", div_dividend_tvalid, 0);
    check("rst_dvs_tvalid", div_divisor_tvalid, 0);
    check("rst_dout_tready", div_dout_tready, 1);
    check("rst_out_x", out_x, 0);
    check("rst_recip", out_w_recip, 0);
    check("rst_dbz", out_div_by_zero, 0);
    reset = 1'b0;

    run_vec(vecs[0], "v0_stall", 10);
    for (int i = 1; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i), 0);

    // Reset while waiting on the divider, then drain the orphaned quotient
    @(negedge clk);
    dly_a = 0; dly_b = 0;
    in_x = 32'h0005_0000; in_y = 32'h0005_0000; in_z = 32'h0005_0000; in_w = 32'h0000_1000;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!(div_dout_tready && !in_ready) && n < 50) begin @(negedge clk); n++; end
    check("wait_reached", div_dout_tready && !in_ready, 1);
    beats0 = beats;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_tvalids", {div_dividend_tvalid, div_divisor_tvalid}, 0);
    check("midrst_out_x", out_x, 0);
    check("midrst_stale_pending", pq.size() > 0, 1);
    reset = 1'b0;
    n = 0;
    while ((pq.size() > 0 || div_dout_tvalid) && n < 50) begin @(negedge clk); n++; end
    check("stale_drained", beats - beats0, 1);
    check("stale_idle", in_ready, 1);
    run_vec(vecs[1], "after_rst", 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
